// File: rtl/spike_encoder.sv
// Signed spike burst encoder: one value in, |value| spaced pulses out.
// Optional SPIKE_ENC_STATS_EN adds a saturating spike_count port.
module spike_encoder #(
  parameter int VAL_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_value,
  input  logic [GAP_W-1:0] gap_cfg,
  input  logic             abort,
  output logic             spike_out,
  output logic             sign_out,
  output logic             busy,
  output logic             done
`ifdef SPIKE_ENC_STATS_EN
  ,
  output logic [15:0]      spike_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    GAP,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [VAL_W-1:0] rem, rem_nx;
  logic [GAP_W-1:0] gap, gap_nx;
  logic [GAP_W-1:0] gcnt, gcnt_nx;
  logic             neg, neg_nx;

  logic             accept;
  logic [VAL_W-1:0] mag_in;
  logic [GAP_W-1:0] gap_in;

  assign accept = in_valid & in_ready;

  // -2^(VAL_W-1) maps onto its own bit pattern, read as unsigned
  assign mag_in = in_value[VAL_W-1]
                ? (~in_value + VAL_W'(1))
                : in_value;

  // a zero gap would merge adjacent pulses
  assign gap_in = (gap_cfg == '0) ? GAP_W'(1) : gap_cfg;

  assign in_ready  = (state == IDLE);
  assign spike_out = (state == FIRE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign sign_out  = neg & busy;

  // state and burst registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      gap   <= '0;
      gcnt  <= '0;
      neg   <= 1'b0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      gap   <= gap_nx;
      gcnt  <= gcnt_nx;
      neg   <= neg_nx;
    end
  end

  // next-state: burst sequencing, abort overrides any busy state
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    gap_nx   = gap;
    gcnt_nx  = gcnt;
    neg_nx   = neg;
    unique case (state)
      IDLE: begin
        if (accept) begin
          rem_nx   = mag_in;
          gap_nx   = gap_in;
          neg_nx   = in_value[VAL_W-1];
          state_nx = (mag_in == '0) ? DONE : FIRE;
        end
      end
      FIRE: begin
        rem_nx   = rem - VAL_W'(1);
        gcnt_nx  = gap;
        state_nx = (rem == VAL_W'(1)) ? DONE : GAP;
      end
      GAP: begin
        if (gcnt <= GAP_W'(1)) begin
          state_nx = FIRE;
        end else begin
          gcnt_nx = gcnt - GAP_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (abort && (state != IDLE)) begin
      state_nx = IDLE;
    end
  end

`ifdef SPIKE_ENC_STATS_EN
  // total spikes since reset, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_count <= '0;
    end else if ((state == FIRE) &&
                 (spike_count != 16'hFFFF)) begin
      spike_count <= spike_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder.
// Hand-computed cycle positions for each burst scenario.
module tb_spike_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_value;
  logic [3:0] gap_cfg;
  logic       abort;
  logic       spike_out;
  logic       sign_out;
  logic       busy;
  logic       done;
`ifdef SPIKE_ENC_STATS_EN
  logic [15:0] spike_count;
`endif

  int total = 0;
  int bad   = 0;

  spike_encoder #(
    .VAL_W(8),
    .GAP_W(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .gap_cfg    (gap_cfg),
    .abort      (abort),
    .spike_out  (spike_out),
    .sign_out   (sign_out),
    .busy       (busy),
    .done       (done)
`ifdef SPIKE_ENC_STATS_EN
    ,
    .spike_count(spike_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // drive at negedge, accept on following edge k
  task automatic send(input logic [7:0] v,
                      input logic [3:0] g);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    gap_cfg  = g;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int i,
                         input logic e_spk, input logic e_sgn,
                         input logic e_bsy, input logic e_dn,
                         input logic e_rdy);
    chk($sformatf("%s.spike@%0d", tag, i), spike_out, e_spk);
    chk($sformatf("%s.sign@%0d", tag, i), sign_out, e_sgn);
    chk($sformatf("%s.busy@%0d", tag, i), busy, e_bsy);
    chk($sformatf("%s.done@%0d", tag, i), done, e_dn);
    chk($sformatf("%s.rdy@%0d", tag, i), in_ready, e_rdy);
  endtask

  int nspk;
  int last;
  int dcyc;
  int sgn_err;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    gap_cfg  = '0;
    abort    = 1'b0;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 1);
`ifdef SPIKE_ENC_STATS_EN
    chk("reset.cnt", spike_count, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // +3, gap 2
    send(8'd3, 4'd2);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk_all("t1", i, (i == 1 || i == 4 || i == 7), 0,
              (i <= 8), (i == 8), (i == 9));
    end

    // -2, gap 0 forced to 1
    send(8'hFE, 4'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk_all("t2", i, (i == 1 || i == 3), (i <= 4),
              (i <= 4), (i == 4), (i == 5));
    end

    // zero value
    send(8'd0, 4'd3);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk_all("t3", i, 0, 0, (i == 1), (i == 1), (i == 2));
    end

    // -128, gap 1
    send(8'h80, 4'd1);
    nspk = 0; last = 0; dcyc = 0; sgn_err = 0;
    for (int i = 1; i <= 257; i++) begin
      @(negedge clk);
      if (spike_out) begin
        nspk++;
        last = i;
      end
      if (done) dcyc = i;
      if (sign_out !== (i <= 256)) sgn_err++;
    end
    chk("t4.nspk", 16'(nspk), 16'd128);
    chk("t4.last", 16'(last), 16'd255);
    chk("t4.done", 16'(dcyc), 16'd256);
    chk("t4.sgn_err", 16'(sgn_err), 16'd0);
    chk("t4.rdy", in_ready, 1'b1);
`ifdef SPIKE_ENC_STATS_EN
    chk("t4.cnt", spike_count, 16'd133);
`endif

    // +5, gap 1, abort sampled at edge k+3
    send(8'd5, 4'd1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk_all("t5", i, (i == 1 || i == 3), 0,
              (i <= 3), 0, (i >= 4));
      abort = (i == 3);
    end
    abort = 1'b0;
`ifdef SPIKE_ENC_STATS_EN
    chk("t5.cnt", spike_count, 16'd135);
`endif

    // abort with in_valid in IDLE still accepts
    @(negedge clk);
    abort = 1'b1;
    send(8'd1, 4'd1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk_all("t5b", i, (i == 1), 0, (i <= 2),
              (i == 2), (i == 3));
    end

    // async reset mid-burst of -4
    send(8'hFC, 4'd1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk_all("t6pre", i, (i != 2), 1, 1, 0, 0);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("t6rst", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6.rdy", in_ready, 1'b1);
`ifdef SPIKE_ENC_STATS_EN
    chk("t6.cnt", spike_count, 16'd0);
`endif
    send(8'd1, 4'd5);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk_all("t6post", i, (i == 1), 0, (i <= 2),
              (i == 2), (i >= 3));
    end
`ifdef SPIKE_ENC_STATS_EN
    chk("t6post.cnt", spike_count, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
